// File: rtl/fft_result_reader.sv
// Unloads one FFT frame from the 4-bank result RAM and streams it over valid/ready.
// Define FFT_RD_DIGITREV_EN to read bins through radix-4 digit reversal (natural order out).
module fft_result_reader #(
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  output logic [A_BIT-1:0]   oADDR_RD_0,
  output logic [A_BIT-1:0]   oADDR_RD_1,
  output logic [A_BIT-1:0]   oADDR_RD_2,
  output logic [A_BIT-1:0]   oADDR_RD_3,
  input  logic [D_BIT-1:0]   iDATA_RE_0,
  input  logic [D_BIT-1:0]   iDATA_RE_1,
  input  logic [D_BIT-1:0]   iDATA_RE_2,
  input  logic [D_BIT-1:0]   iDATA_RE_3,
  output logic [D_BIT-1:0]   oDATA,
  output logic [A_BIT+1:0]   oINDEX,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam int IW    = A_BIT + 2;
  localparam int NST   = RD_LAT + 1;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(2 * DEPTH + 1);
  localparam logic [IW-1:0] LAST_BIN = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     k_q, r_k;
  logic [A_BIT-1:0]  addr_q;
  logic              done_q, done_d;
  logic              issue, push, pop;
  logic [CW-1:0]     count, inflight;
  logic [NST-1:0]    pv_q;
  logic [1:0]        pbank_q [NST];
  logic [IW-1:0]     pidx_q  [NST];
  logic [D_BIT-1:0]  rd_word;
  logic [D_BIT-1:0]  f_data [DEPTH];
  logic [IW-1:0]     f_idx  [DEPTH];
  logic [DEPTH-1:0]  f_last;
  logic [PW-1:0]     wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    r_k = k_q;
`ifdef FFT_RD_DIGITREV_EN
    for (int unsigned d = 0; d < IW / 2; d++)
      r_k[2*d +: 2] = k_q[IW-2-2*d +: 2];
`endif
  end

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NST; i++)
      inflight = inflight + CW'(pv_q[i]);
  end

  assign oVALID = (count != '0);
  assign pop    = oVALID & iREADY;
  assign push   = pv_q[NST-1];
  // A beat leaving this cycle frees its slot, so full rate holds with one head entry.
  assign issue  = (state_q == ISSUE) && ((count + inflight) < (CW'(DEPTH) + CW'(pop)));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (iSTART) state_d = ISSUE;
      ISSUE: if (issue && k_q == LAST_BIN) state_d = DRAIN;
      DRAIN: if (count == '0 && inflight == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && iSTART) k_q <= '0;
      else if (issue)                k_q <= k_q + IW'(1);
      if (issue) addr_q <= r_k[IW-1:2];
    end
  end

  // Bank select and bin index ride alongside the read until the data returns.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < NST; i++) begin
        pbank_q[i] <= '0;
        pidx_q[i]  <= '0;
      end
    end else begin
      pv_q       <= {pv_q[NST-2:0], issue};
      pbank_q[0] <= r_k[1:0];
      pidx_q[0]  <= k_q;
      for (int unsigned i = 1; i < NST; i++) begin
        pbank_q[i] <= pbank_q[i-1];
        pidx_q[i]  <= pidx_q[i-1];
      end
    end
  end

  always_comb begin
    unique case (pbank_q[NST-1])
      2'd0:    rd_word = iDATA_RE_0;
      2'd1:    rd_word = iDATA_RE_1;
      2'd2:    rd_word = iDATA_RE_2;
      default: rd_word = iDATA_RE_3;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      f_last <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        f_data[i] <= '0;
        f_idx[i]  <= '0;
      end
    end else begin
      if (push) begin
        f_data[wr_ptr] <= rd_word;
        f_idx[wr_ptr]  <= pidx_q[NST-1];
        f_last[wr_ptr] <= (pidx_q[NST-1] == LAST_BIN);
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign oDATA      = f_data[rd_ptr];
  assign oINDEX     = f_idx[rd_ptr];
  assign oLAST      = oVALID & f_last[rd_ptr];
  assign oBUSY      = (state_q != IDLE);
  assign oDONE      = done_q;
  assign oADDR_RD_0 = addr_q;
  assign oADDR_RD_1 = addr_q;
  assign oADDR_RD_2 = addr_q;
  assign oADDR_RD_3 = addr_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: two instances (RD_LAT 1 and 3) share stimulus and are
// checked against a bin-order reference model and a RAM model holding {salt, bank, addr}.
module tb_fft_result_reader;

  localparam int D  = 17;
  localparam int A  = 8;
  localparam int IW = A + 2;
  localparam int N  = 1024;

  logic iCLK = 1'b0;
  logic iRESET, iSTART, iREADY;
  always #5 iCLK = ~iCLK;

  logic [A-1:0]  addr   [2][4];
  logic [D-1:0]  dre    [2][4];
  logic [D-1:0]  odata  [2];
  logic [IW-1:0] oidx   [2];
  logic          ovalid [2], olast [2], obusy [2], odone [2];
  logic [6:0]    salt;

  fft_result_reader #(.D_BIT(D), .A_BIT(A), .RD_LAT(1)) u_lat1 (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oADDR_RD_0(addr[0][0]), .oADDR_RD_1(addr[0][1]), .oADDR_RD_2(addr[0][2]), .oADDR_RD_3(addr[0][3]),
    .iDATA_RE_0(dre[0][0]), .iDATA_RE_1(dre[0][1]), .iDATA_RE_2(dre[0][2]), .iDATA_RE_3(dre[0][3]),
    .oDATA(odata[0]), .oINDEX(oidx[0]), .oVALID(ovalid[0]), .iREADY(iREADY),
    .oLAST(olast[0]), .oBUSY(obusy[0]), .oDONE(odone[0]));

  fft_result_reader #(.D_BIT(D), .A_BIT(A), .RD_LAT(3)) u_lat3 (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oADDR_RD_0(addr[1][0]), .oADDR_RD_1(addr[1][1]), .oADDR_RD_2(addr[1][2]), .oADDR_RD_3(addr[1][3]),
    .iDATA_RE_0(dre[1][0]), .iDATA_RE_1(dre[1][1]), .iDATA_RE_2(dre[1][2]), .iDATA_RE_3(dre[1][3]),
    .oDATA(odata[1]), .oINDEX(oidx[1]), .oVALID(ovalid[1]), .iREADY(iREADY),
    .oLAST(olast[1]), .oBUSY(obusy[1]), .oDONE(odone[1]));

  // Result RAM: each bank returns {salt, bank, address} LAT clocks after the address.
  for (genvar c = 0; c < 2; c++) begin : g_ram
    localparam int LAT = (c == 0) ? 1 : 3;
    logic [A-1:0] pipe [4][LAT];
    always @(posedge iCLK)
      for (int b = 0; b < 4; b++) begin
        pipe[b][0] <= addr[c][b];
        for (int i = 1; i < LAT; i++) pipe[b][i] <= pipe[b][i-1];
      end
    for (genvar b = 0; b < 4; b++) begin : g_bank
      assign dre[c][b] = {salt, 2'(b), pipe[b][LAT-1]};
    end
  end

  int n_assert = 0, n_fail = 0, cyc = 0;
  int exp_k [2], beats [2], dones [2], t0 [2];
  bit active [2], pend [2];
  bit fullrate;
  int lat [2] = '{1, 3};

  function automatic int storage_pos(input int k);
    int r = k;
`ifdef FFT_RD_DIGITREV_EN
    int x = k;
    r = 0;
    for (int d = 0; d < A / 2 + 1; d++) begin
      r = r * 4 + x % 4;
      x = x / 4;
    end
`endif
    return r;
  endfunction

  function automatic logic [D-1:0] exp_word(input int k);
    int r = storage_pos(k);
    return {salt, 2'(r % 4), 8'(r / 4)};
  endfunction

  task automatic check(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[lat%0d]: observed %0h expected %0h", tag, lat[c], got, exp);
    end
  endtask

  // One clock: record what the coming edge accepts, then check the settled outputs.
  task automatic tick();
    bit acc [2];
    bit st, exp_done;
    st = iSTART;
    for (int c = 0; c < 2; c++) acc[c] = ovalid[c] && iREADY;
    @(negedge iCLK);
    cyc++;
    for (int c = 0; c < 2; c++) begin
      exp_done = pend[c];
      pend[c]  = 1'b0;
      if (acc[c]) begin
        if (exp_k[c] == N - 1) pend[c] = 1'b1;
        exp_k[c]++;
        beats[c]++;
      end
      if (exp_done) begin
        active[c] = 1'b0;
        dones[c]++;
      end else if (st && !active[c]) begin
        active[c] = 1'b1;
        exp_k[c]  = 0;
        beats[c]  = 0;
        t0[c]     = cyc;
      end
      check("done", c, 32'(odone[c]), 32'(exp_done));
      check("busy", c, 32'(obusy[c]), 32'(active[c]));
      if (!active[c]) check("idle_valid", c, 32'(ovalid[c]), 32'd0);
      if (ovalid[c]) begin
        check("index", c, 32'(oidx[c]), 32'(exp_k[c]));
        check("data",  c, 32'(odata[c]), 32'(exp_word(exp_k[c])));
        check("last",  c, 32'(olast[c]), 32'(exp_k[c] == N - 1));
        if (fullrate) check("beat_time", c, 32'(cyc), 32'(t0[c] + lat[c] + 2 + exp_k[c]));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int c = 0; c < 2; c++) begin
      check({tag, "_valid"}, c, 32'(ovalid[c]), 32'd0);
      check({tag, "_busy"},  c, 32'(obusy[c]),  32'd0);
      check({tag, "_done"},  c, 32'(odone[c]),  32'd0);
      check({tag, "_last"},  c, 32'(olast[c]),  32'd0);
      check({tag, "_data"},  c, 32'(odata[c]),  32'd0);
      check({tag, "_index"}, c, 32'(oidx[c]),   32'd0);
      for (int b = 0; b < 4; b++) check({tag, "_addr"}, c, 32'(addr[c][b]), 32'd0);
    end
  endtask

  // mode 0: ready held high; 1: toggling with a 20-clock stall and iSTART re-pulses; 2: random ready
  task automatic run_frame(input int mode, input int bound);
    int target = dones[0] + 1;
    bit drain_pulsed = 1'b0;
    salt = 7'($urandom);
    fullrate = (mode == 0);
    for (int i = 0; i < bound; i++) begin
      if (dones[0] >= target && dones[1] >= target) break;
      case (mode)
        0:       iREADY = 1'b1;
        1:       iREADY = (i >= 400 && i < 420) ? 1'b0 : (i % 2 == 0);
        default: iREADY = 1'($urandom_range(0, 1));
      endcase
      iSTART = (i == 0) || (mode == 1 && i == 50);
      if (mode == 1 && !drain_pulsed && active[0] && active[1] &&
          exp_k[0] >= N - 2 && exp_k[1] >= N - 2) begin
        iSTART = 1'b1;
        drain_pulsed = 1'b1;
      end
      tick();
    end
    iSTART = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("frame_done_count", c, 32'(dones[c]), 32'(target));
      check("frame_beats", c, 32'(beats[c]), 32'(N));
    end
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      exp_k[c] = 0; beats[c] = 0; dones[c] = 0; t0[c] = 0;
      active[c] = 1'b0; pend[c] = 1'b0;
    end
    fullrate = 1'b0;
    salt   = 7'($urandom);
    iRESET = 1'b1;
    iSTART = 1'b0;
    iREADY = 1'b0;
    repeat (3) @(negedge iCLK);
    chk_zero("reset");
    iRESET = 1'b0;
    repeat (2) tick();

    run_frame(0, 1200);
    run_frame(1, 4000);
    run_frame(2, 5000);

    // Reset while beat 100 is at the head, then a clean frame afterwards.
    salt = 7'($urandom);
    fullrate = 1'b1;
    iREADY = 1'b1;
    for (int i = 0; i < 300 && exp_k[0] != 100; i++) begin
      iSTART = (i == 0);
      tick();
    end
    iSTART = 1'b0;
    check("reach_beat100", 0, 32'(exp_k[0]), 32'd100);
    iRESET = 1'b1;
    #1;
    chk_zero("midreset");
    for (int c = 0; c < 2; c++) begin
      active[c] = 1'b0; pend[c] = 1'b0; exp_k[c] = 0;
    end
    @(negedge iCLK);
    iRESET = 1'b0;
    repeat (30) tick();
    run_frame(0, 1200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
